hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and stall scheduler for the 5-stage MIPS core. It produces the forwarding selects, the stall/flush controls and the multi-cycle divide sequencing that the datapath consumes. Forwarding and load-use/branch hazard decisions are combinational. The divide sequencer is a registered FSM with a down-counter that freezes F/D/E while the external divider runs.

## Interface
- DIV_CYCLES, 32, total stall cycles per divide, legal range ≥ 2
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-low
- RsD, RtD  in  5  source registers in ID
- RsE, RtE  in  5  source registers in EX
- BranchD  in  1  beq in ID
- RegWriteE, MemtoRegE  in  1  EX-stage control
- WriteRegE  in  5  EX destination register
- RegWriteM, MemtoRegM  in  1  MEM-stage control
- WriteRegM  in  5  MEM destination register
- RegWriteW  in  1  WB register-write enable
- WriteRegW  in  5  WB destination register
- DivE  in  1  valid div/divu instruction in EX
- StallF, StallD  out  1  hold PC and IF/ID register
- StallE  out  1  hold ID/EX register
- FlushE  out  1  clear ID/EX register (inserts a bubble)
- ForwardAD, ForwardBD  out  1  branch comparator: 1 = ALUResultM
- ForwardAE, ForwardBE  out  2  ALU source: 00 = register file, 01 = WB result, 10 = ALUResultM
- div_start  out  1  one-cycle start pulse to the divider
- hilo_we  out  1  one-cycle HI/LO write enable
- div_busy  out  1  divide stall active

## Operation
- **ForwardAE**
  - 10 if RegWriteM & WriteRegM≠0 & WriteRegM==RsE.
  - Else 01 if RegWriteW & WriteRegW≠0 & WriteRegW==RsE.
  - Else 00.
  - MEM has priority over WB. Register $0 is never forwarded.
- **ForwardBE:** same rules, using RtE.
- **ForwardAD/BD:** 1 when RegWriteM & WriteRegM≠0 & WriteRegM==RsD (or RtD for BD).
- **lwstall:** MemtoRegE & RegWriteE & WriteRegE≠0 & (WriteRegE==RsD | WriteRegE==RtD).
- **branchstall:** BranchD & WriteRegX≠0 & (WriteRegX==RsD | WriteRegX==RtD), where X is either
  - RegWriteE (destination WriteRegE), or
  - MemtoRegM (destination WriteRegM).
- **Divide FSM states:** IDLE, BUSY, DONE.
  - IDLE → BUSY when DivE. On that transition, cnt ← DIV_CYCLES-2.
  - In BUSY: if cnt==0, go to DONE; else cnt ← cnt-1.
  - DONE → IDLE unconditionally.
- **Divide outputs:**
  - div_busy = (IDLE & DivE) | BUSY.
  - div_start = IDLE & DivE.
  - hilo_we = DONE.
- **Stall/flush combination:**
  - StallF = StallD = lwstall | branchstall | div_busy.
  - StallE = div_busy.
  - FlushE = (lwstall | branchstall) & ~div_busy. While EX is held, it is never flushed.
- cnt is ⌈log2(DIV_CYCLES)⌉ bits wide and unsigned. It never underflows, because BUSY exits at 0.

## Timing
- Forwarding, lwstall, branchstall, StallF/D/E, FlushE and div_busy are same-cycle combinational functions of their inputs.
- **Divide sequence,** DivE first seen in cycle t:
  - Stall is asserted in cycles t … t+DIV_CYCLES-1.
  - div_start is high in t only.
  - BUSY occupies t+1 … t+DIV_CYCLES-1.
  - DONE is at t+DIV_CYCLES: hilo_we=1, StallE=0. The div leaves EX at the end of that cycle.
- **No self-retrigger:** in DONE the FSM ignores DivE. A back-to-back div reaches EX in the cycle after DONE, when the FSM is back in IDLE, and starts a fresh sequence.
- **lw/branch hazard during divide:** suppressed while div_busy. It is re-evaluated in DONE and resolves normally there.
- **Reset:** asynchronous, when rst=0.
  - State → IDLE and cnt → 0 immediately, including mid-divide. The external divider is abandoned.
  - With the state at IDLE, div_start is 0 whenever DivE=0, and hilo_we=0.
  - With all inputs at 0: every output is 0.

## Structure
- Shared package `hazard_pkg` holds:
  - the forward-select constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the enum div_state_t {IDLE, BUSY, DONE}.
- Sub-module `div_seq` contains the FSM and counter.
  - Ports: clk, rst, DivE, div_busy, div_start, hilo_we.
  - Parameter: DIV_CYCLES.
- The top level holds the combinational hazard logic and the output OR-ing.

## Test plan
- **MEM forward:** RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 → ForwardAE=10. Repeat with WriteRegM=0 (so the W match applies) → 01.
- **$0 guard:** RsE=0, WriteRegM=0, RegWriteM=1 → ForwardAE=00. RsD=RtD=0 with a load to $0 in EX → lwstall=0.
- **Load-use:** MemtoRegE=RegWriteE=1, WriteRegE=8, RtD=8 → StallF=StallD=FlushE=1, StallE=0. The next cycle with MemtoRegE=0 clears all of them.
- **Branch stall:** BranchD=1, RsD=3, RegWriteE=1, WriteRegE=3 → stall and flush for 1 cycle. Then MemtoRegM=1, WriteRegM=3 → one further cycle of stall.
- **Divide, DIV_CYCLES=32:** DivE held high from cycle 0 →
  - div_start only in cycle 0;
  - StallF/D/E=1 in cycles 0–31;
  - hilo_we=1 in cycle 32;
  - no second div_start in cycle 32.
  - Concurrent load-use in cycle 10 gives FlushE=0.
- **Reset mid-divide:** rst low in cycle 15 of a divide → div_busy=0 asynchronously. After release, DivE=0 keeps the FSM in IDLE.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: forward-select encodings and divide FSM states shared by the hazard unit.
package hazard_pkg;
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
endpackage

// File: rtl/hazard_ctrl_div_seq.sv
// div_seq: multi-cycle divide sequencer; holds the pipeline while the external divider runs.
module div_seq
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic DivE,
    output logic div_busy,
    output logic div_start,
    output logic hilo_we
);
    localparam int CW = $clog2(DIV_CYCLES);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (DivE) begin
                state_d = BUSY;
                cnt_d   = CW'(DIV_CYCLES - 2);
            end
            BUSY: if (cnt_q == '0) state_d = DONE;
                  else cnt_d = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // DONE deliberately ignores DivE so a div cannot restart itself before leaving EX
    assign div_start = (state_q == IDLE) && DivE;
    assign div_busy  = div_start || (state_q == BUSY);
    assign hilo_we   = (state_q == DONE);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use/branch stalls and divide stall merging for the 5-stage core.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic       BranchD,
    input  logic       RegWriteE,
    input  logic       MemtoRegE,
    input  logic [4:0] WriteRegE,
    input  logic       RegWriteM,
    input  logic       MemtoRegM,
    input  logic [4:0] WriteRegM,
    input  logic       RegWriteW,
    input  logic [4:0] WriteRegW,
    input  logic       DivE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       div_start,
    output logic       hilo_we,
    output logic       div_busy
);
    logic m_ok, w_ok, e_ok, lm_ok, lwstall, branchstall, hz;

    div_seq #(.DIV_CYCLES(DIV_CYCLES)) u_div_seq (
        .clk      (clk),
        .rst      (rst),
        .DivE     (DivE),
        .div_busy (div_busy),
        .div_start(div_start),
        .hilo_we  (hilo_we)
    );

    always_comb begin
        m_ok        = RegWriteM && (WriteRegM != 5'd0);
        w_ok        = RegWriteW && (WriteRegW != 5'd0);
        e_ok        = RegWriteE && (WriteRegE != 5'd0);
        lm_ok       = MemtoRegM && (WriteRegM != 5'd0);
        ForwardAE   = (m_ok && WriteRegM == RsE) ? FWD_MEM : (w_ok && WriteRegW == RsE) ? FWD_WB : FWD_REG;
        ForwardBE   = (m_ok && WriteRegM == RtE) ? FWD_MEM : (w_ok && WriteRegW == RtE) ? FWD_WB : FWD_REG;
        ForwardAD   = m_ok && (WriteRegM == RsD);
        ForwardBD   = m_ok && (WriteRegM == RtD);
        lwstall     = MemtoRegE && e_ok && (WriteRegE == RsD || WriteRegE == RtD);
        branchstall = BranchD && ((e_ok && (WriteRegE == RsD || WriteRegE == RtD)) ||
                                  (lm_ok && (WriteRegM == RsD || WriteRegM == RtD)));
        hz          = lwstall || branchstall;
        StallF      = hz || div_busy;
        StallD      = hz || div_busy;
        StallE      = div_busy;
        // a held EX stage must keep its instruction, so the bubble is suppressed
        FlushE      = hz && !div_busy;
    end
endmodule
